match_enumerator: RTL and testbench

//  Parametrised, sequential successor to the single-result priority encoder.

---
 rtl/match_enumerator.sv | 86 ++++++++
 tb/tb_match_enumerator.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/match_enumerator.sv
// Sequential match enumerator: accepts a CAM match vector and emits the index
// of every set bit, one per output handshake, in the configured priority order.
module match_enumerator #(
  parameter int  WIDTH     = 32,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_last_o,
  output logic             out_empty_o
);

  typedef enum logic [1:0] {IDLE, ENUM, EMPTY} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] enc_idx;
  logic [WIDTH-1:0] pending_clr;
  logic             single;

  // Last match wins, so scan away from the priority end.
  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (pending_q[i]) enc_idx = IDX_W'(i);
      end else begin
        if (pending_q[WIDTH-1-i]) enc_idx = IDX_W'(WIDTH-1-i);
      end
    end
  end

  assign pending_clr = pending_q & ~(WIDTH'(1) << enc_idx);
  assign single      = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q != IDLE);
  assign out_idx_o   = (state_q == ENUM) ? enc_idx : '0;
  assign out_last_o  = ((state_q == ENUM) && single) || (state_q == EMPTY);
  assign out_empty_o = (state_q == EMPTY);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (|in_data_i) begin
            pending_d = in_data_i;
            state_d   = ENUM;
          end else begin
            state_d   = EMPTY;
          end
        end
      end
      ENUM: begin
        if (out_ready_i) begin
          pending_d = pending_clr;
          if (single) state_d = IDLE;
        end
      end
      EMPTY: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_match_enumerator.sv
// Directed and model-checked random stimulus for match_enumerator; one LSB-first
// and one MSB-first instance share all inputs and run in lockstep.
module tb_match_enumerator;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] in_data;
  logic        rdy0, rdy1, val0, val1, last0, last1, emp0, emp1;
  logic [4:0]  idx0, idx1;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  match_enumerator #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_data_i(in_data), .out_valid_o(val0), .out_ready_i(out_ready),
    .out_idx_o(idx0), .out_last_o(last0), .out_empty_o(emp0));

  match_enumerator #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_data_i(in_data), .out_valid_o(val1), .out_ready_i(out_ready),
    .out_idx_o(idx1), .out_last_o(last1), .out_empty_o(emp1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the beat on show now, then move to the next sample point.
  task automatic beat(input string tag, input int i0, input int i1, input bit last, input bit emp);
    chk({tag, "_val0"},  32'(val0),  32'd1);
    chk({tag, "_val1"},  32'(val1),  32'd1);
    chk({tag, "_rdy0"},  32'(rdy0),  32'd0);
    chk({tag, "_idx0"},  32'(idx0),  32'(i0));
    chk({tag, "_idx1"},  32'(idx1),  32'(i1));
    chk({tag, "_last0"}, 32'(last0), 32'(last));
    chk({tag, "_last1"}, 32'(last1), 32'(last));
    chk({tag, "_emp0"},  32'(emp0),  32'(emp));
    chk({tag, "_emp1"},  32'(emp1),  32'(emp));
    @(negedge clk);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_rdy0"}, 32'(rdy0), 32'd1);
    chk({tag, "_rdy1"}, 32'(rdy1), 32'd1);
    chk({tag, "_val0"}, 32'(val0), 32'd0);
    chk({tag, "_val1"}, 32'(val1), 32'd0);
  endtask

  task automatic send(input logic [31:0] v);
    chk("send_rdy", 32'(rdy0), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  initial begin
    int q0[$];
    int q1[$];
    logic [31:0] vec;
    int nexp, beats, guard;
    bit rdy;

    // Reset held with a valid vector on the input: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
    @(negedge clk);
    chk("rst1_val0", 32'(val0), 32'd0);
    chk("rst1_val1", 32'(val1), 32'd0);
    @(negedge clk);
    chk("rst2_val0", 32'(val0), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    idle_chk("post_rst");
    chk("post_rst_idx",  32'(idx0),  32'd0);
    chk("post_rst_last", 32'(last0), 32'd0);
    chk("post_rst_emp",  32'(emp0),  32'd0);

    // Ordering
    send(32'h8000_0011);
    beat("ord_b0", 0, 31, 1'b0, 1'b0);
    beat("ord_b1", 4, 4, 1'b0, 1'b0);
    beat("ord_b2", 31, 0, 1'b1, 1'b0);
    idle_chk("ord_done");

    // Zero vector
    send(32'h0);
    beat("zero", 0, 0, 1'b1, 1'b1);
    idle_chk("zero_done");

    // Backpressure holds the first beat
    out_ready = 1'b0;
    send(32'h0000_0006);
    beat("bp_h0", 1, 2, 1'b0, 1'b0);
    beat("bp_h1", 1, 2, 1'b0, 1'b0);
    beat("bp_h2", 1, 2, 1'b0, 1'b0);
    out_ready = 1'b1;
    beat("bp_b0", 1, 2, 1'b0, 1'b0);
    beat("bp_b1", 2, 1, 1'b1, 1'b0);
    idle_chk("bp_done");

    // Extreme indices
    send(32'h8000_0001);
    beat("edge_b0", 0, 31, 1'b0, 1'b0);
    beat("edge_b1", 31, 0, 1'b1, 1'b0);
    idle_chk("edge_done");

    // All-ones, interrupted by reset after three beats
    send(32'hFFFF_FFFF);
    beat("ones_b0", 0, 31, 1'b0, 1'b0);
    beat("ones_b1", 1, 30, 1'b0, 1'b0);
    beat("ones_b2", 2, 29, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_chk("mid_rst");
    send(32'h1);
    beat("after_rst", 0, 0, 1'b1, 1'b0);
    idle_chk("after_rst_done");

    // Random vectors against a per-vector index-list model
    for (int v = 0; v < 800; v++) begin
      case ($urandom_range(0, 19))
        0:       vec = 32'h0;
        1:       vec = 32'hFFFF_FFFF;
        default: vec = $urandom & $urandom & $urandom;
      endcase
      q0.delete();
      q1.delete();
      for (int i = 0; i < 32; i++) if (vec[i]) q0.push_back(i);
      for (int i = 31; i >= 0; i--) if (vec[i]) q1.push_back(i);
      if (vec == 32'h0) begin
        q0.push_back(0);
        q1.push_back(0);
      end
      nexp  = q0.size();
      beats = 0;
      guard = 0;
      send(vec);
      while (q0.size() > 0 && guard < 400) begin
        chk("rnd_val",   32'(val0),  32'd1);
        chk("rnd_idx0",  32'(idx0),  32'(q0[0]));
        chk("rnd_idx1",  32'(idx1),  32'(q1[0]));
        chk("rnd_last0", 32'(last0), 32'(q0.size() == 1));
        chk("rnd_last1", 32'(last1), 32'(q1.size() == 1));
        chk("rnd_emp",   32'(emp0),  32'(vec == 32'h0));
        rdy = ($urandom_range(0, 3) != 0);
        out_ready = rdy;
        if (rdy) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
          beats++;
        end
        @(negedge clk);
        guard++;
      end
      chk("rnd_beats", 32'(beats), 32'(nexp));
      idle_chk("rnd_done");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
